// File: rtl/gpr_regfile.sv
// General-purpose register file with a per-register pending-write scoreboard for RAW stalls.
// Define GPR_BYPASS_EN to forward the writeback port to the read ports in the same cycle.
module gpr_regfile #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 32,
    parameter int CW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rf_wr_en,
    input  logic [AW-1:0] rf_wr_addr,
    input  logic [DW-1:0] rf_wr_data,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    input  logic          rd_use_a,
    input  logic          rd_use_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic          rd_hazard_a,
    output logic          rd_hazard_b,
    output logic          stall,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_addr,
    input  logic          sb_clr,
    output logic          sb_err
);

    localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};

    logic [DW-1:0] regs_q [NREG];
    logic [CW-1:0] pend_q [NREG];
    logic [CW-1:0] pend_d [NREG];
    logic          sb_err_q, sb_err_d;
    logic          claim_ok;
    logic          claim_hit, rel_hit;

    always_comb begin
        rd_data_a   = regs_q[rd_addr_a];
        rd_data_b   = regs_q[rd_addr_b];
        rd_hazard_a = (pend_q[rd_addr_a] != '0);
        rd_hazard_b = (pend_q[rd_addr_b] != '0);
`ifdef GPR_BYPASS_EN
        // A release of the last outstanding write resolves the hazard in the same cycle.
        if (rf_wr_en && (rf_wr_addr == rd_addr_a)) begin
            rd_data_a = rf_wr_data;
            if (pend_q[rd_addr_a] == CW'(1)) rd_hazard_a = 1'b0;
        end
        if (rf_wr_en && (rf_wr_addr == rd_addr_b)) begin
            rd_data_b = rf_wr_data;
            if (pend_q[rd_addr_b] == CW'(1)) rd_hazard_b = 1'b0;
        end
`endif
    end

    assign stall    = (rd_use_a & rd_hazard_a) | (rd_use_b & rd_hazard_b);
    assign claim_ok = claim_en & ~stall;
    assign sb_err   = sb_err_q;

    always_comb begin
        sb_err_d  = sb_err_q;
        claim_hit = 1'b0;
        rel_hit   = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            pend_d[i] = pend_q[i];
            claim_hit = claim_ok && (claim_addr == AW'(i));
            rel_hit   = rf_wr_en && (rf_wr_addr == AW'(i));
            if (sb_clr) begin
                pend_d[i] = '0;
            end else if (claim_hit && !rel_hit) begin
                if (pend_q[i] == PEND_MAX) sb_err_d = 1'b1;
                else pend_d[i] = pend_q[i] + CW'(1);
            end else if (rel_hit && !claim_hit) begin
                if (pend_q[i] == '0) sb_err_d = 1'b1;
                else pend_d[i] = pend_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (rf_wr_en) regs_q[rf_wr_addr] <= rf_wr_data;
            for (int i = 0; i < NREG; i++) pend_q[i] <= pend_d[i];
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_gpr_regfile.sv
// Table-driven bench for gpr_regfile; expectations follow GPR_BYPASS_EN when it is defined.
module tb_gpr_regfile;

`ifdef GPR_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif
    localparam logic [31:0] DB = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rf_wr_en = 1'b0;
    logic [3:0]  rf_wr_addr = '0;
    logic [31:0] rf_wr_data = '0;
    logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic        rd_use_a = 1'b0, rd_use_b = 1'b0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_hazard_a, rd_hazard_b, stall;
    logic        claim_en = 1'b0;
    logic [3:0]  claim_addr = '0;
    logic        sb_clr = 1'b0;
    logic        sb_err;

    gpr_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_use_a   (rd_use_a),
        .rd_use_b   (rd_use_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_hazard_a(rd_hazard_a),
        .rd_hazard_b(rd_hazard_b),
        .stall      (stall),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .sb_clr     (sb_clr),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  a, b;
        logic        use_a, use_b, claim, clr;
        logic [3:0]  claim_addr;
        logic [31:0] ea, eb;
        logic        eha, ehb, est, eerr;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] ea, eb;
        logic        eha, ehb, est, eerr;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] a, input logic [3:0] b, input logic ua,
                                input logic ub, input logic ce, input logic [3:0] ca,
                                input logic clr, input logic [31:0] ea, input logic [31:0] eb,
                                input logic eha, input logic ehb, input logic est,
                                input logic eerr, input string name);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.a = a; v.b = b;
        v.use_a = ua; v.use_b = ub; v.claim = ce; v.claim_addr = ca; v.clr = clr;
        v.ea = ea; v.eb = eb; v.eha = eha; v.ehb = ehb; v.est = est; v.eerr = eerr;
        v.name = name;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = sb_q.pop_front();
        n_vec++;
        if ({rd_data_a, rd_data_b, rd_hazard_a, rd_hazard_b, stall, sb_err} !==
            {e.ea, e.eb, e.eha, e.ehb, e.est, e.eerr}) begin
            n_miss++;
            $display("FAIL %s: got a=%h b=%h hza=%b hzb=%b stall=%b err=%b, want a=%h b=%h hza=%b hzb=%b stall=%b err=%b",
                     e.name, rd_data_a, rd_data_b, rd_hazard_a, rd_hazard_b, stall, sb_err,
                     e.ea, e.eb, e.eha, e.ehb, e.est, e.eerr);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rf_wr_en = v.wr_en; rf_wr_addr = v.wr_addr; rf_wr_data = v.wr_data;
        rd_addr_a = v.a; rd_addr_b = v.b; rd_use_a = v.use_a; rd_use_b = v.use_b;
        claim_en = v.claim; claim_addr = v.claim_addr; sb_clr = v.clr;
        e.ea = v.ea; e.eb = v.eb; e.eha = v.eha; e.ehb = v.ehb; e.est = v.est;
        e.eerr = v.eerr; e.name = v.name;
        sb_q.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        exp_t e;
        // Reset: every register reads zero.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 0, 0, 4'(2*k), 4'(2*k+1), 0, 0, 0, 0, 0,
                              0, 0, 0, 0, 0, 0, "reset_read"));
        // Write then read r3 (claimed first so the release is legal).
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, "claim_r3"));
        vecs.push_back(mk(1, 3, DB, 3, 3, 0, 0, 0, 0, 0, BP ? DB : 0, BP ? DB : 0,
                          ~BP, ~BP, 0, 0, "write_r3"));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, DB, 0, 0, 0, 0, 0, "read_r3"));
        // RAW stall on r5; the stalled claim of r6 must be dropped.
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, "claim_r5"));
        vecs.push_back(mk(0, 0, 0, 5, 0, 1, 0, 1, 6, 0, 0, 0, 1, 0, 1, 0, "stall_r5_a"));
        vecs.push_back(mk(0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "stall_r5_b"));
        vecs.push_back(mk(1, 5, 32'h55, 5, 6, 1, 0, 0, 0, 0, BP ? 32'h55 : 0, 0,
                          ~BP, 0, ~BP, 0, "release_r5"));
        vecs.push_back(mk(0, 0, 0, 5, 6, 1, 1, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0, "after_r5"));
        // Same-cycle claim and release on r7 keeps pend at 2.
        vecs.push_back(mk(0, 0, 0, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, "claim_r7_1"));
        vecs.push_back(mk(0, 0, 0, 7, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, "claim_r7_2"));
        vecs.push_back(mk(1, 7, 32'h77, 7, 0, 0, 0, 1, 7, 0, BP ? 32'h77 : 0, 0,
                          1, 0, 0, 0, "claim_rel_r7"));
        vecs.push_back(mk(1, 7, 32'h78, 7, 0, 0, 0, 0, 0, 0, BP ? 32'h78 : 32'h77, 0,
                          1, 0, 0, 0, "rel_r7_1"));
        vecs.push_back(mk(1, 7, 32'h79, 7, 0, 0, 0, 0, 0, 0, BP ? 32'h79 : 32'h78, 0,
                          ~BP, 0, 0, 0, "rel_r7_2"));
        vecs.push_back(mk(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 32'h79, 0, 0, 0, 0, 0, "r7_clear"));
        // Overflow: fourth claim of r15 saturates at 3 and flags an error.
        vecs.push_back(mk(0, 0, 0, 0, 15, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0, "claim_r15_1"));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 0, 0, 15, 0, 0, 1, 15, 0, 0, 0, 0, 1, 0, 0, "claim_r15_n"));
        vecs.push_back(mk(0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "overflow_err"));
        vecs.push_back(mk(1, 15, 1, 0, 15, 0, 0, 0, 0, 0, 0, BP ? 32'h1 : 0, 0, 1, 0, 1,
                          "rel_r15_1"));
        vecs.push_back(mk(1, 15, 2, 0, 15, 0, 0, 0, 0, 0, 0, BP ? 32'h2 : 32'h1, 0, 1, 0, 1,
                          "rel_r15_2"));
        vecs.push_back(mk(1, 15, 3, 0, 15, 0, 0, 0, 0, 0, 0, BP ? 32'h3 : 32'h2, 0, ~BP, 0, 1,
                          "rel_r15_3"));
        vecs.push_back(mk(0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, "r15_drained"));
        // Clear with r1, r4 outstanding; clear beats the same-cycle claim.
        vecs.push_back(mk(0, 0, 0, 1, 4, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "claim_r1"));
        vecs.push_back(mk(0, 0, 0, 1, 4, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, 1, "claim_r4"));
        vecs.push_back(mk(0, 0, 0, 1, 4, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 1, "sb_clr"));
        vecs.push_back(mk(0, 0, 0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "after_clr"));
        vecs.push_back(mk(0, 0, 0, 3, 7, 0, 0, 0, 0, 0, DB, 32'h79, 0, 0, 0, 1, "regs_kept"));
        // Outstanding claim on r9 just before an asynchronous reset.
        vecs.push_back(mk(0, 0, 0, 9, 3, 1, 0, 1, 9, 0, 0, DB, 0, 0, 0, 1, "claim_r9"));
        vecs.push_back(mk(0, 0, 0, 9, 3, 1, 0, 0, 0, 0, 0, DB, 1, 0, 1, 1, "stall_r9"));

        #12 rst_n = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // Mid-cycle reset must clear state with no clock edge.
        #1 rst_n = 1'b0;
        #1;
        e.ea = 0; e.eb = 0; e.eha = 0; e.ehb = 0; e.est = 0; e.eerr = 0;
        e.name = "async_reset";
        sb_q.push_back(e);
        check_out();
        #1 rst_n = 1'b1;

        // Underflow: unclaimed write still lands and sets the sticky flag.
        run_vec(mk(1, 2, 32'h1234, 2, 0, 0, 0, 0, 0, 0, BP ? 32'h1234 : 0, 0, 0, 0, 0, 0,
                   "underflow_wr"));
        run_vec(mk(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 1, "underflow_err"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gpr_regfile.md
# gpr_regfile

- General-purpose register file and pending-write scoreboard for the 32-bit in-order pipeline.
- Write port: sinks the writeback stage's `rf_wr_en`/`rf_wr_addr`/`rf_wr_data`.
- Read ports: serves two operand reads to the decode stage.
- Scoreboard: tracks in-flight destination registers so decode can stall on RAW hazards.
- Sits between decode (read, claim) and writeback (write, release).

## Interface
Parameters:
- `NREG`, 16: number of architectural registers (r15 = return address).
- `AW`, 4: register address width; `2**AW == NREG`.
- `DW`, 32: register data width.
- `CW`, 2: pending-write counter width per register; max outstanding writes per register = `2**CW-1`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rf_wr_en`  in  1  write strobe from writeback.
- `rf_wr_addr`  in  AW  write register index.
- `rf_wr_data`  in  DW  write data.
- `rd_addr_a` / `rd_addr_b`  in  AW  operand read indices from decode.
- `rd_use_a` / `rd_use_b`  in  1  operand actually consumed by the decoding instruction.
- `rd_data_a` / `rd_data_b`  out  DW  operand values (combinational).
- `rd_hazard_a` / `rd_hazard_b`  out  1  source register has an unresolved pending write.
- `stall`  out  1  `(rd_use_a & rd_hazard_a) | (rd_use_b & rd_hazard_b)`.
- `claim_en`  in  1  decode issues an instruction that will write `claim_addr`.
- `claim_addr`  in  AW  destination index (r15 for calls).
- `sb_clr`  in  1  synchronous clear of all pending counters.
- `sb_err`  out  1  sticky scoreboard overflow/underflow flag.

## Operation
- **Storage:** `NREG` x `DW` flops. No hardwired-zero register. All registers are writable, including r0 and r15.
- **Write:** when `rf_wr_en` = 1, `reg[rf_wr_addr] <= rf_wr_data` at the clock edge.
- **Read:** asynchronous. `rd_data_x = reg[rd_addr_x]`, subject to the bypass described under Configuration.
- **Scoreboard:** per-register counter `pend[i]`, `CW` bits wide.
  - Effective claim: `claim_en & ~stall`. Claims are gated internally by stall.
  - Release: `rf_wr_en`, which releases `rf_wr_addr`.
  - Claim only: `pend += 1`.
  - Release only: `pend -= 1`.
  - Claim and release on the same register in the same cycle: `pend` unchanged.
  - Claim and release on different registers: both counters update independently.
- **Overflow:** a claim at `pend == 2**CW-1` leaves the counter saturated and sets `sb_err`.
- **Underflow:** a release at `pend == 0` leaves the counter at 0 and sets `sb_err`. The data write still occurs.
- **Hazard:** `rd_hazard_x = (pend[rd_addr_x] != 0)`. The bypass exception is described under Configuration.
- **Clear:** `sb_clr` zeroes every `pend[i]` and takes priority over a same-cycle claim or release. It does not clear `sb_err` or register contents.

## Timing
- **Reset:** asynchronous assertion.
  - All registers = 0, all `pend` = 0, `sb_err` = 0.
  - Therefore `rd_data_a`/`rd_data_b` = 0, `rd_hazard_a`/`rd_hazard_b` = 0, `stall` = 0.
  - Reset mid-operation discards all pending claims and in-flight register contents immediately.
- **Write-to-read latency:** 1 cycle without bypass. The value is visible on the read port the cycle after `rf_wr_en`.
- **Claim-to-hazard latency:** 1 cycle. `rd_hazard` rises the cycle after the accepted claim.
- **Release-to-hazard-drop:** 1 cycle without bypass; same cycle with bypass (see below).
- **Flag outputs:** `stall`, `rd_hazard_*` and `rd_data_*` are combinational from the current state and current inputs. `sb_err` is registered.
- **Handshake:** none; every strobe is accepted in the cycle presented, except claims gated by `stall`.

## Configuration
- Macro: `GPR_BYPASS_EN`.
- **Defined:**
  - If `rf_wr_en` and `rf_wr_addr == rd_addr_x`, then `rd_data_x = rf_wr_data` in the same cycle.
  - `rd_hazard_x` is suppressed when `pend[rd_addr_x] == 1` and that register is being released this cycle.
  - Result: zero-cycle WB-to-decode forwarding.
- **Undefined:** reads return flop contents only, and hazards follow `pend` alone. This costs one extra stall cycle per RAW dependency on writeback.

## Test plan
- **Reset:** apply reset, then read r0..r15 -> all read 0; `stall` = 0; `sb_err` = 0.
- **Write then read:** write r3 = 0xDEADBEEF, then read a = r3 next cycle -> `rd_data_a` = 0xDEADBEEF. With `GPR_BYPASS_EN`, reading a = r3 in the same cycle as the write also returns 0xDEADBEEF.
- **RAW stall:**
  - Claim r5, then read a = r5 with `rd_use_a` = 1 -> `stall` = 1 until the r5 write.
  - Release at cycle N -> `stall` drops at N with the macro defined, N+1 without.
- **Simultaneous claim and release:** claim r7 twice, then claim and release r7 in one cycle -> `pend[r7]` stays 2; two further releases -> hazard clears.
- **Error cases:**
  - Claim r15 four times (CW = 2) -> `sb_err` = 1 and `pend` = 3.
  - After reset, write r2 with `pend` = 0 -> r2 updated and `sb_err` = 1.
- **Clear mid-flight:** `sb_clr` with claims outstanding on r1, r4 -> all hazards 0 the next cycle; `sb_err` and register values unchanged.
